// File: rtl/branch_predictor_if.sv
// Fetch/execute-facing signal bundle of the branch predictor.
// The pipeline holds the master side and the predictor holds the slave side.
interface branch_predictor_if;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [31:0] ex_pc;
  logic        ex_br_en;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  modport master (
    output if_pc, ex_valid, ex_is_branch, ex_pc, ex_br_en, ex_target,
           ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, mispredict, redirect_pc,
           branch_count, mispredict_count
  );

  modport slave (
    input  if_pc, ex_valid, ex_is_branch, ex_pc, ex_br_en, ex_target,
           ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, mispredict, redirect_pc,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit counter predictor with BTB, mispredict detection and perf counters.
// Define BRANCH_PREDICT_EN for the dynamic tables; otherwise static predict-not-taken.
module branch_predictor #(
  parameter int ENTRIES = 64
) (
  input  logic              clk,
  input  logic              rst,
  branch_predictor_if.slave bp
);

  logic        update;
  logic        mispredict;
  logic [31:0] branch_count_q,     branch_count_d;
  logic [31:0] mispredict_count_q, mispredict_count_d;

  // A branch resolving while rst is high is dropped entirely.
  assign update = bp.ex_valid & bp.ex_is_branch & ~rst;

`ifdef BRANCH_PREDICT_EN
  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = 30 - IDX;

  logic            valid_q  [ENTRIES];
  logic [1:0]      ctr_q    [ENTRIES];
  logic [TAGW-1:0] tag_q    [ENTRIES];
  logic [31:0]     target_q [ENTRIES];

  logic [IDX-1:0]  if_idx, ex_idx;
  logic [TAGW-1:0] if_tag, ex_tag;
  logic            if_hit, ex_hit;
  logic            pred_taken;
  logic [1:0]      ctr_d;
  logic [1:0]      unused_if_pc_lsb;

  assign if_idx = bp.if_pc[IDX+1:2];
  assign if_tag = bp.if_pc[31:IDX+2];
  assign ex_idx = bp.ex_pc[IDX+1:2];
  assign ex_tag = bp.ex_pc[31:IDX+2];
  assign unused_if_pc_lsb = bp.if_pc[1:0];

  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  assign pred_taken     = if_hit & ctr_q[if_idx][1] & ~rst;
  assign bp.pred_taken  = pred_taken;
  assign bp.pred_target = pred_taken ? target_q[if_idx] : 32'h0;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    ctr_d = bp.ex_br_en ? 2'b10 : 2'b01;
    if (ex_hit) begin
      if (bp.ex_br_en) ctr_d = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'd1;
      else             ctr_d = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (update) begin
      valid_q[ex_idx] <= 1'b1;
      ctr_q[ex_idx]   <= ctr_d;
    end
  end

  // NOTE: tag/target storage is not reset; valid_q guards it, so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (update) begin
      tag_q[ex_idx] <= ex_tag;
      if (!ex_hit || bp.ex_br_en) target_q[ex_idx] <= bp.ex_target;
    end
  end

  assign mispredict = update &
                      ((bp.ex_br_en != bp.ex_pred_taken) |
                       (bp.ex_br_en & (bp.ex_pred_target != bp.ex_target)));
  assign bp.redirect_pc = mispredict ? (bp.ex_br_en ? bp.ex_target : bp.ex_pc + 32'd4)
                                     : 32'h0;
`else
  logic unused_static;

  assign unused_static  = ^{bp.if_pc, bp.ex_pc, bp.ex_pred_taken, bp.ex_pred_target};
  assign bp.pred_taken  = 1'b0;
  assign bp.pred_target = 32'h0;
  assign mispredict     = update & bp.ex_br_en;
  assign bp.redirect_pc = mispredict ? bp.ex_target : 32'h0;
`endif

  assign bp.mispredict = mispredict;

  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (update)     branch_count_d     = branch_count_q + 32'd1;
    if (mispredict) mispredict_count_d = mispredict_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count_q     <= 32'h0;
      mispredict_count_q <= 32'h0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign bp.branch_count     = branch_count_q;
  assign bp.mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor; expectations follow BRANCH_PREDICT_EN
// (dynamic tables) or its absence (static predict-not-taken).
module tb_branch_predictor;

`ifdef BRANCH_PREDICT_EN
  localparam bit DYN = 1'b1;
`else
  localparam bit DYN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predictor_if bp ();
  branch_predictor #(.ENTRIES(64)) dut (.clk(clk), .rst(rst), .bp(bp));

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_bc = 32'h0;
  logic [31:0] exp_mc = 32'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic b, input logic [31:0] pc,
                          input logic en, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
    bp.ex_valid       = v;
    bp.ex_is_branch   = b;
    bp.ex_pc          = pc;
    bp.ex_br_en       = en;
    bp.ex_target      = tgt;
    bp.ex_pred_taken  = ptk;
    bp.ex_pred_target = ptgt;
  endtask

  task automatic idle();
    drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Advance over an edge that carries a resolved branch, tracking the counters.
  task automatic commit(input logic exp_mis);
    tick();
    exp_bc = exp_bc + 32'd1;
    if (exp_mis) exp_mc = exp_mc + 32'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bp.if_pc = 32'h100;
    drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    tick();
    tick();
    if (bp.mispredict !== 1'b0) begin bad++; $display("FAIL rst_mis got=%0b want=0", bp.mispredict); end
    total++;
    if (bp.redirect_pc !== 32'h0) begin bad++; $display("FAIL rst_redir got=%0h want=0", bp.redirect_pc); end
    total++;
    if (bp.pred_taken !== 1'b0) begin bad++; $display("FAIL rst_pred got=%0b want=0", bp.pred_taken); end
    total++;
    rst = 1'b0;
    idle();
    #1;
    if (bp.pred_taken !== 1'b0) begin bad++; $display("FAIL init_pred got=%0b want=0", bp.pred_taken); end
    total++;
    if (bp.pred_target !== 32'h0) begin bad++; $display("FAIL init_tgt got=%0h want=0", bp.pred_target); end
    total++;
    if (bp.branch_count !== 32'h0) begin bad++; $display("FAIL init_bc got=%0h want=0", bp.branch_count); end
    total++;
    if (bp.mispredict_count !== 32'h0) begin bad++; $display("FAIL init_mc got=%0h want=0", bp.mispredict_count); end
    total++;
  endtask

  task automatic test_allocate();
    bp.if_pc = 32'h100;
    drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    #1;
    if (bp.mispredict !== 1'b1) begin bad++; $display("FAIL alloc_mis got=%0b want=1", bp.mispredict); end
    total++;
    if (bp.redirect_pc !== 32'h80) begin bad++; $display("FAIL alloc_redir got=%0h want=80", bp.redirect_pc); end
    total++;
    if (bp.pred_taken !== 1'b0) begin bad++; $display("FAIL alloc_nobypass got=%0b want=0", bp.pred_taken); end
    total++;
    commit(1'b1);
    idle();
    #1;
    if (bp.pred_taken !== DYN) begin bad++; $display("FAIL alloc_pred got=%0b want=%0b", bp.pred_taken, DYN); end
    total++;
    if (bp.pred_target !== (DYN ? 32'h80 : 32'h0))
    begin bad++; $display("FAIL alloc_tgt got=%0h want=%0h", bp.pred_target, DYN ? 32'h80 : 32'h0); end
    total++;
    if (bp.branch_count !== 32'd1) begin bad++; $display("FAIL alloc_bc got=%0h want=1", bp.branch_count); end
    total++;
    if (bp.mispredict_count !== 32'd1) begin bad++; $display("FAIL alloc_mc got=%0h want=1", bp.mispredict_count); end
    total++;
  endtask

  task automatic test_wrong_target();
    bp.if_pc = 32'h100;
    drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h90, 1'b1, 32'h80);
    #1;
    if (bp.mispredict !== 1'b1) begin bad++; $display("FAIL wtgt_mis got=%0b want=1", bp.mispredict); end
    total++;
    if (bp.redirect_pc !== 32'h90) begin bad++; $display("FAIL wtgt_redir got=%0h want=90", bp.redirect_pc); end
    total++;
    commit(1'b1);
    idle();
    #1;
    if (bp.pred_target !== (DYN ? 32'h90 : 32'h0))
    begin bad++; $display("FAIL wtgt_tgt got=%0h want=%0h", bp.pred_target, DYN ? 32'h90 : 32'h0); end
    total++;
  endtask

  task automatic test_aliasing();
    drive_ex(1'b1, 1'b1, 32'h200, 1'b0, 32'h300, 1'b0, 32'h0);
    #1;
    if (bp.mispredict !== 1'b0) begin bad++; $display("FAIL alias_mis got=%0b want=0", bp.mispredict); end
    total++;
    if (bp.redirect_pc !== 32'h0) begin bad++; $display("FAIL alias_redir got=%0h want=0", bp.redirect_pc); end
    total++;
    commit(1'b0);
    idle();
    bp.if_pc = 32'h100;
    #1;
    if (bp.pred_taken !== 1'b0) begin bad++; $display("FAIL alias_old got=%0b want=0", bp.pred_taken); end
    total++;
    bp.if_pc = 32'h200;
    #1;
    if (bp.pred_taken !== 1'b0) begin bad++; $display("FAIL alias_new got=%0b want=0", bp.pred_taken); end
    total++;
  endtask

  task automatic test_saturation();
    logic ep;
    logic em;
    bp.if_pc = 32'h200;
    // Entry 0x200 starts at ctr=01: four taken updates walk 01->10->11->11->11.
    for (int i = 0; i < 4; i++) begin
      ep = DYN && (i > 0);
      em = DYN ? (i == 0) : 1'b1;
      drive_ex(1'b1, 1'b1, 32'h200, 1'b1, 32'h240, ep, ep ? 32'h240 : 32'h0);
      #1;
      if (bp.pred_taken !== ep) begin bad++; $display("FAIL sat_t%0d_pred got=%0b want=%0b", i, bp.pred_taken, ep); end
      total++;
      if (bp.mispredict !== em) begin bad++; $display("FAIL sat_t%0d_mis got=%0b want=%0b", i, bp.mispredict, em); end
      total++;
      commit(em);
    end
    // Not-taken from ctr=11 predicted taken.
    drive_ex(1'b1, 1'b1, 32'h200, 1'b0, 32'h240, DYN, DYN ? 32'h240 : 32'h0);
    #1;
    if (bp.mispredict !== DYN) begin bad++; $display("FAIL sat_nt1_mis got=%0b want=%0b", bp.mispredict, DYN); end
    total++;
    if (bp.redirect_pc !== (DYN ? 32'h204 : 32'h0))
    begin bad++; $display("FAIL sat_nt1_redir got=%0h want=%0h", bp.redirect_pc, DYN ? 32'h204 : 32'h0); end
    total++;
    commit(DYN);
    idle();
    #1;
    if (bp.pred_taken !== DYN) begin bad++; $display("FAIL sat_ctr10_pred got=%0b want=%0b", bp.pred_taken, DYN); end
    total++;
    if (bp.pred_target !== (DYN ? 32'h240 : 32'h0))
    begin bad++; $display("FAIL sat_ctr10_tgt got=%0h want=%0h", bp.pred_target, DYN ? 32'h240 : 32'h0); end
    total++;
    // 10 -> 01 (mispredicted), then 01 -> 00 and 00 -> 00 (correctly not-taken).
    drive_ex(1'b1, 1'b1, 32'h200, 1'b0, 32'h240, DYN, DYN ? 32'h240 : 32'h0);
    commit(DYN);
    for (int i = 0; i < 2; i++) begin
      drive_ex(1'b1, 1'b1, 32'h200, 1'b0, 32'h240, 1'b0, 32'h0);
      #1;
      if (bp.pred_taken !== 1'b0) begin bad++; $display("FAIL sat_low%0d_pred got=%0b want=0", i, bp.pred_taken); end
      total++;
      if (bp.mispredict !== 1'b0) begin bad++; $display("FAIL sat_low%0d_mis got=%0b want=0", i, bp.mispredict); end
      total++;
      commit(1'b0);
    end
    // One taken from saturated 00 only reaches 01.
    drive_ex(1'b1, 1'b1, 32'h200, 1'b1, 32'h240, 1'b0, 32'h0);
    #1;
    if (bp.redirect_pc !== 32'h240) begin bad++; $display("FAIL sat_up_redir got=%0h want=240", bp.redirect_pc); end
    total++;
    commit(1'b1);
    idle();
    #1;
    if (bp.pred_taken !== 1'b0) begin bad++; $display("FAIL sat_ctr01_pred got=%0b want=0", bp.pred_taken); end
    total++;
    if (bp.branch_count !== exp_bc) begin bad++; $display("FAIL sat_bc got=%0h want=%0h", bp.branch_count, exp_bc); end
    total++;
    if (bp.mispredict_count !== exp_mc) begin bad++; $display("FAIL sat_mc got=%0h want=%0h", bp.mispredict_count, exp_mc); end
    total++;
  endtask

  task automatic test_stall();
    bp.if_pc = 32'h300;
    drive_ex(1'b0, 1'b1, 32'h300, 1'b1, 32'h80, 1'b0, 32'h0);
    #1;
    if (bp.mispredict !== 1'b0) begin bad++; $display("FAIL stall_mis got=%0b want=0", bp.mispredict); end
    total++;
    if (bp.redirect_pc !== 32'h0) begin bad++; $display("FAIL stall_redir got=%0h want=0", bp.redirect_pc); end
    total++;
    tick();
    drive_ex(1'b1, 1'b0, 32'h300, 1'b1, 32'h80, 1'b0, 32'h0);
    #1;
    if (bp.mispredict !== 1'b0) begin bad++; $display("FAIL nonbr_mis got=%0b want=0", bp.mispredict); end
    total++;
    tick();
    idle();
    #1;
    if (bp.pred_taken !== 1'b0) begin bad++; $display("FAIL stall_pred got=%0b want=0", bp.pred_taken); end
    total++;
    if (bp.branch_count !== exp_bc) begin bad++; $display("FAIL stall_bc got=%0h want=%0h", bp.branch_count, exp_bc); end
    total++;
    if (bp.mispredict_count !== exp_mc) begin bad++; $display("FAIL stall_mc got=%0h want=%0h", bp.mispredict_count, exp_mc); end
    total++;
  endtask

  task automatic test_back_to_back();
    bp.if_pc = 32'h400;
    drive_ex(1'b1, 1'b1, 32'h400, 1'b1, 32'h500, 1'b0, 32'h0);
    #1;
    if (bp.mispredict !== 1'b1) begin bad++; $display("FAIL b2b_1_mis got=%0b want=1", bp.mispredict); end
    total++;
    commit(1'b1);
    drive_ex(1'b1, 1'b1, 32'h400, 1'b1, 32'h500, DYN, DYN ? 32'h500 : 32'h0);
    #1;
    if (bp.pred_taken !== DYN) begin bad++; $display("FAIL b2b_2_pred got=%0b want=%0b", bp.pred_taken, DYN); end
    total++;
    if (bp.pred_target !== (DYN ? 32'h500 : 32'h0))
    begin bad++; $display("FAIL b2b_2_tgt got=%0h want=%0h", bp.pred_target, DYN ? 32'h500 : 32'h0); end
    total++;
    if (bp.mispredict !== !DYN) begin bad++; $display("FAIL b2b_2_mis got=%0b want=%0b", bp.mispredict, !DYN); end
    total++;
    commit(!DYN);
    drive_ex(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h10, 1'b1, 32'h10);
    #1;
    if (bp.mispredict !== DYN) begin bad++; $display("FAIL wrap_mis got=%0b want=%0b", bp.mispredict, DYN); end
    total++;
    if (bp.redirect_pc !== 32'h0) begin bad++; $display("FAIL wrap_redir got=%0h want=0", bp.redirect_pc); end
    total++;
    commit(DYN);
    idle();
    #1;
    if (bp.branch_count !== exp_bc) begin bad++; $display("FAIL b2b_bc got=%0h want=%0h", bp.branch_count, exp_bc); end
    total++;
    if (bp.mispredict_count !== exp_mc) begin bad++; $display("FAIL b2b_mc got=%0h want=%0h", bp.mispredict_count, exp_mc); end
    total++;
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    bp.if_pc = 32'h400;
    drive_ex(1'b1, 1'b1, 32'h300, 1'b1, 32'h80, 1'b0, 32'h0);
    #1;
    if (bp.mispredict !== 1'b0) begin bad++; $display("FAIL rstmid_mis got=%0b want=0", bp.mispredict); end
    total++;
    if (bp.pred_taken !== 1'b0) begin bad++; $display("FAIL rstmid_pred got=%0b want=0", bp.pred_taken); end
    total++;
    tick();
    rst = 1'b0;
    idle();
    exp_bc = 32'h0;
    exp_mc = 32'h0;
    #1;
    if (bp.pred_taken !== 1'b0) begin bad++; $display("FAIL rstmid_after_pred got=%0b want=0", bp.pred_taken); end
    total++;
    bp.if_pc = 32'h300;
    #1;
    if (bp.pred_taken !== 1'b0) begin bad++; $display("FAIL rstmid_drop_pred got=%0b want=0", bp.pred_taken); end
    total++;
    if (bp.branch_count !== exp_bc) begin bad++; $display("FAIL rstmid_bc got=%0h want=%0h", bp.branch_count, exp_bc); end
    total++;
    if (bp.mispredict_count !== exp_mc) begin bad++; $display("FAIL rstmid_mc got=%0h want=%0h", bp.mispredict_count, exp_mc); end
    total++;
  endtask

  initial begin
    rst = 1'b1;
    bp.if_pc = 32'h0;
    idle();
    test_reset();
    test_allocate();
    test_wrong_target();
    test_aliasing();
    test_saturation();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
